// File: rtl/sys_rst_gen.sv
// sys_rst_gen: power-on/soft/watchdog reset sequencer (watchdog enabled by defining SYS_RST_WDT_EN)
module sys_rst_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYC = 16,
  parameter int CPU_DELAY   = 4,
  parameter int WDT_CYC     = 1024
) (
  input  logic       clk_init,
  input  logic       rst_init,
  input  logic       soft_rst_req,
  input  logic       wdt_kick,
  output logic       periph_rst_n,
  output logic       cpu_rst_n,
  output logic       rst_done,
  output logic [1:0] rst_cause
);
  localparam int CMAX = (STRETCH_CYC > CPU_DELAY) ? STRETCH_CYC : CPU_DELAY;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] S_LAST = CW'(STRETCH_CYC - 1);
  localparam logic [CW-1:0] P_LAST = CW'(CPU_DELAY - 1);

  typedef enum logic [2:0] {HOLD, SYNC, STRETCH, PERIPH, RUN} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   soft_prev, soft_edge, wdt_expire;
  logic                   periph_nx, cpu_nx, done_nx;
  logic [1:0]             cause_nx;

  assign soft_edge = soft_rst_req & ~soft_prev;

`ifdef SYS_RST_WDT_EN
  localparam int WW = (WDT_CYC > 2) ? $clog2(WDT_CYC) : 1;
  logic [WW-1:0] wdt_cnt;
  assign wdt_expire = (state == RUN) && !wdt_kick && (wdt_cnt == WW'(WDT_CYC - 1));
  // watchdog counts unkicked RUN cycles and restarts on any exit from RUN
  always_ff @(posedge clk_init or negedge rst_init)
    if (!rst_init) wdt_cnt <= '0;
    else wdt_cnt <= (state != RUN || wdt_kick || wdt_expire || soft_edge) ? '0 : wdt_cnt + 1'b1;
`else
  logic unused_wdt;
  assign wdt_expire = 1'b0;
  assign unused_wdt = wdt_kick & (WDT_CYC >= 2);
`endif

  // release of rst_init reaches the FSM only through this chain
  always_ff @(posedge clk_init or negedge rst_init)
    if (!rst_init) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], 1'b1};

  // previous soft request; resets high so a request held through reset is not an edge
  always_ff @(posedge clk_init or negedge rst_init)
    if (!rst_init) soft_prev <= 1'b1;
    else soft_prev <= soft_rst_req;

  // next-state and next-output logic; outputs hold unless a transition changes them
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    periph_nx = periph_rst_n;
    cpu_nx    = cpu_rst_n;
    done_nx   = rst_done;
    cause_nx  = rst_cause;
    case (state)
      HOLD: state_nx = SYNC;
      SYNC:
        if (sync[SYNC_STAGES-1]) begin
          state_nx  = (STRETCH_CYC == 1) ? PERIPH : STRETCH;
          periph_nx = (STRETCH_CYC == 1);
          cnt_nx    = (STRETCH_CYC == 1) ? '0 : CW'(1);
        end
      STRETCH:
        if (cnt == S_LAST) begin
          state_nx  = PERIPH;
          periph_nx = 1'b1;
          cnt_nx    = '0;
        end else cnt_nx = cnt + 1'b1;
      PERIPH:
        if (cnt == P_LAST) begin
          state_nx = RUN;
          cpu_nx   = 1'b1;
          done_nx  = 1'b1;
          cnt_nx   = '0;
        end else cnt_nx = cnt + 1'b1;
      RUN:
        if (soft_edge || wdt_expire) begin
          state_nx  = STRETCH;
          periph_nx = 1'b0;
          cpu_nx    = 1'b0;
          done_nx   = 1'b0;
          cause_nx  = soft_edge ? 2'b01 : 2'b10;
          cnt_nx    = '0;
        end
      default: state_nx = HOLD;
    endcase
  end

  // state, counter and all outputs registered so nothing glitches
  always_ff @(posedge clk_init or negedge rst_init)
    if (!rst_init) begin
      state        <= HOLD;
      cnt          <= '0;
      periph_rst_n <= 1'b0;
      cpu_rst_n    <= 1'b0;
      rst_done     <= 1'b0;
      rst_cause    <= 2'b00;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      periph_rst_n <= periph_nx;
      cpu_rst_n    <= cpu_nx;
      rst_done     <= done_nx;
      rst_cause    <= cause_nx;
    end
endmodule

// File: doc/sys_rst_gen.md
SYS_RST_GEN -- requirements
Module: sys_rst_gen

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops for the rst_init release (minimum 2).
REQ-002 SHALL have parameter STRETCH_CYC, default 16: number of cycles from the synchronized release to periph_rst_n going high (minimum 1).
REQ-003 SHALL have parameter CPU_DELAY, default 4: number of cycles from periph_rst_n high to cpu_rst_n high (minimum 1).
REQ-004 SHALL have parameter WDT_CYC, default 1024: number of RUN cycles without a kick before a watchdog reset (minimum 2).
REQ-005 SHALL have port clk_init, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_init, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have port soft_rst_req, input, 1 bit: software reset request; only a 0->1 transition triggers.
REQ-008 SHALL have port wdt_kick, input, 1 bit: watchdog service pulse.
REQ-009 SHALL have port periph_rst_n, output, 1 bit: active-low reset for the bus and peripherals.
REQ-010 SHALL have port cpu_rst_n, output, 1 bit: active-low reset for the CPU core.
REQ-011 SHALL have port rst_done, output, 1 bit: 1 only in state RUN.
REQ-012 SHALL have port rst_cause, output, 2 bits: cause of the last reset (00 power-on, 01 soft, 10 watchdog, 11 unused).

Function
REQ-013 SHALL implement the FSM states HOLD, SYNC, STRETCH, PERIPH, RUN.
REQ-014 HOLD: SHALL move to SYNC on the first edge with rst_init high.
REQ-015 SYNC: SHALL wait for the synchronizer output; all outputs stay low.
REQ-016 Edge numbering: E1 = first rising edge at which rst_init is sampled high.
REQ-017 Release timing: periph_rst_n SHALL rise at edge E(SYNC_STAGES+STRETCH_CYC), which is E18 with defaults.
REQ-018 Release timing: cpu_rst_n and rst_done SHALL rise at edge E(SYNC_STAGES+STRETCH_CYC+CPU_DELAY), which is E22 with defaults.
REQ-019 STRETCH SHALL count STRETCH_CYC edges and then enter PERIPH with periph_rst_n=1.
REQ-020 PERIPH SHALL count CPU_DELAY edges and then enter RUN with cpu_rst_n=1 and rst_done=1.
REQ-021 Once in RUN, the outputs SHALL NOT glitch; every output SHALL be driven directly from a flop.
REQ-022 soft_rst_req SHALL be registered every cycle and a rising edge detected from the registered value (prev register resets to 1, so a request held high through reset does not trigger).
REQ-023 A detected soft edge in RUN SHALL, on the next edge: drive periph_rst_n=0, cpu_rst_n=0, rst_done=0; set rst_cause=01; clear the counter; enter STRETCH.
REQ-024 A soft edge in any state other than RUN SHALL be ignored and SHALL NOT be queued.
REQ-025 Counter widths SHALL be sized from the parameters; no count may wrap before its terminal value.
REQ-026 Assertion of rst_init in any state, mid-sequence included, SHALL immediately force HOLD and zero all outputs.

Reset
REQ-027 While rst_init=0: periph_rst_n=0, cpu_rst_n=0, rst_done=0, rst_cause=00, state=HOLD, all counters 0, synchronizer flops 0.
REQ-028 Reset SHALL assert asynchronously; release SHALL be seen internally only through the SYNC_STAGES-flop synchronizer.

Configuration
REQ-029 Macro SYS_RST_WDT_EN defined: SHALL include a watchdog counter that increments each RUN cycle and clears on wdt_kick=1 or on leaving RUN.
REQ-030 Macro SYS_RST_WDT_EN defined: when the counter reaches WDT_CYC-1 without a kick, the block SHALL take the soft-reset path with rst_cause=10.
REQ-031 Macro SYS_RST_WDT_EN defined, same-cycle conflicts: a kick coinciding with expiry SHALL win (no reset); a soft edge coinciding with expiry SHALL win (rst_cause=01).
REQ-032 Macro SYS_RST_WDT_EN not defined: no watchdog logic; wdt_kick SHALL be ignored; rst_cause SHALL never be 10.

Verification
REQ-033 Power-on: rst_init held 0 for 105 cycles, then 1 (defaults) -> periph_rst_n rises at E18, cpu_rst_n and rst_done at E22, rst_cause=00.
REQ-034 Soft reset: 0->1 on soft_rst_req in RUN -> next edge all outputs 0 and rst_cause=01; periph_rst_n high 16 edges later, cpu_rst_n 4 edges after that.
REQ-035 Mid-sequence reset: rst_init driven 0 at E10 between edges -> outputs 0 asynchronously; on rerelease the full E18/E22 timing repeats.
REQ-036 Held soft request: soft_rst_req=1 throughout power-on -> no soft reset after RUN; a later 1->0->1 triggers exactly one soft reset.
REQ-037 Watchdog (SYS_RST_WDT_EN): no kick for 1024 RUN cycles -> reset with rst_cause=10; kick every 1000 cycles -> no reset for 10000 cycles.
REQ-038 Watchdog conflict (SYS_RST_WDT_EN): soft edge on the expiry cycle -> rst_cause=01; kick on the expiry cycle -> stays in RUN.
